// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared definitions for the data-cache writeback path: system
//               bus tag encoding, line-address width, burst length and the
//               writeback FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   // Line address = byte address with the 6 offset bits dropped
   localparam int LINE_ADDR_W   = 58;
   // Data beats per 512-bit line on a 64-bit bus
   localparam int BEATS         = 8;

   localparam int SYSBUS_WRITE  = 1;
   localparam int SYSBUS_MEMORY = 1;
   // Request tag carried by every writeback burst
   localparam int SYSBUS_WR_TAG = (SYSBUS_WRITE << 8) | (SYSBUS_MEMORY << 12);

   typedef enum logic [2:0] {
      WB_IDLE = 3'd0,
      WB_ARB  = 3'd1,
      WB_ADDR = 3'd2,
      WB_DATA = 3'd3,
      WB_DONE = 3'd4
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_line_fifo
// Description : DEPTH-entry FIFO of {line address, line data} with parallel
//               address match for refill lookup and eviction coalescing.
// Ports       : push_valid/push_addr/push_line - accepted eviction
//               pop          - retire the head entry
//               head_locked  - head is being drained; never coalesce into it
//               lk_addr      - lookup line address -> lk_hit / lk_line
//               co_hit       - push_addr matches a coalescable entry
//               head_addr/head_line - oldest entry
//               empty/full/multi    - occupancy (multi = more than one entry)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_line_fifo
   import dcache_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int LINE_WIDTH = 512
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_valid,
   input  logic [LINE_ADDR_W-1:0] push_addr,
   input  logic [LINE_WIDTH-1:0]  push_line,
   input  logic                   pop,
   input  logic                   head_locked,
   input  logic [LINE_ADDR_W-1:0] lk_addr,
   output logic                   lk_hit,
   output logic [LINE_WIDTH-1:0]  lk_line,
   output logic                   co_hit,
   output logic [LINE_ADDR_W-1:0] head_addr,
   output logic [LINE_WIDTH-1:0]  head_line,
   output logic                   empty,
   output logic                   full,
   output logic                   multi
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [LINE_ADDR_W-1:0] r_addr [DEPTH];
   logic [LINE_WIDTH-1:0]  r_line [DEPTH];
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [PTR_W-1:0]       w_co_idx;
   logic                   w_append;

   // Walk entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      lk_hit   = 1'b0;
      lk_line  = '0;
      co_hit   = 1'b0;
      w_co_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = r_rd_ptr + PTR_W'(k);
         if (k < int'(r_count)) begin
            if (r_addr[idx] == lk_addr) begin
               lk_hit  = 1'b1;
               lk_line = r_line[idx];
            end
            if ((r_addr[idx] == push_addr) && !(head_locked && (k == 0))) begin
               co_hit   = 1'b1;
               w_co_idx = idx;
            end
         end
      end
   end

   assign w_append  = push_valid & ~co_hit;
   assign head_addr = r_addr[r_rd_ptr];
   assign head_line = r_line[r_rd_ptr];
   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_W'(DEPTH));
   assign multi     = (r_count > CNT_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_append) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_append) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: entries are qualified by the occupancy count.
   always_ff @(posedge clk) begin
      if (push_valid) begin
         if (co_hit) begin
            r_line[w_co_idx] <= push_line;
         end else begin
            r_addr[r_wr_ptr] <= push_addr;
            r_line[r_wr_ptr] <= push_line;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_writeback_buffer
// Description : Holds evicted dirty lines and drains each as a system-bus
//               write burst (address beat + BEATS data beats) after winning
//               the bus arbiter. Supports refill lookup and coalescing.
// Ports       : wb_*  - eviction push interface (valid/ready)
//               lk_*  - combinational refill lookup
//               arb_* - bus arbiter request/grant
//               bus_* - system bus request channel
//               busy  - entries pending or burst in progress
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_writeback_buffer
   import dcache_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int LINE_WIDTH     = 512,
   parameter int DEPTH          = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wb_valid,
   output logic                      wb_ready,
   input  logic [63:0]               wb_addr,
   input  logic [LINE_WIDTH-1:0]     wb_line,
   input  logic [63:0]               lk_addr,
   output logic                      lk_hit,
   output logic [LINE_WIDTH-1:0]     lk_line,
   output logic                      busy,
   output logic                      arb_req,
   input  logic                      arb_gnt,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   output logic                      bus_respack
);

   localparam int BEAT_W = $clog2(BEATS);

   wb_state_t                r_state;
   logic [BEAT_W-1:0]        r_beat;
   logic [BEAT_W-1:0]        w_next_beat;
   logic                     w_push;
   logic                     w_append;
   logic                     w_co_hit;
   logic                     w_empty;
   logic                     w_full;
   logic                     w_multi;
   logic [LINE_ADDR_W-1:0]   w_head_addr;
   logic [LINE_WIDTH-1:0]    w_head_line;
   logic                     w_unused_offset;

   assign w_unused_offset = ^{wb_addr[5:0], lk_addr[5:0]};

   // A matching address is always accepted because it coalesces in place.
   assign wb_ready    = ~w_full | w_co_hit;
   assign w_push      = wb_valid & wb_ready;
   assign w_append    = w_push & ~w_co_hit;
   assign busy        = ~w_empty | (r_state != WB_IDLE);
   assign bus_respack = 1'b0;
   assign w_next_beat = r_beat + 1'b1;

   // The head is locked from ARB onwards; in DONE it is popped on the same
   // edge, so a matching push must append rather than be lost with the head.
   wb_line_fifo #(
      .DEPTH      (DEPTH),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (w_push),
      .push_addr   (wb_addr[63:6]),
      .push_line   (wb_line),
      .pop         (r_state == WB_DONE),
      .head_locked (r_state != WB_IDLE),
      .lk_addr     (lk_addr[63:6]),
      .lk_hit      (lk_hit),
      .lk_line     (lk_line),
      .co_hit      (w_co_hit),
      .head_addr   (w_head_addr),
      .head_line   (w_head_line),
      .empty       (w_empty),
      .full        (w_full),
      .multi       (w_multi)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= WB_IDLE;
         r_beat     <= '0;
         arb_req    <= 1'b0;
         bus_reqcyc <= 1'b0;
         bus_req    <= '0;
         bus_reqtag <= '0;
      end else begin
         case (r_state)
            WB_IDLE: begin
               if (!w_empty) begin
                  r_state <= WB_ARB;
                  arb_req <= 1'b1;
               end
            end
            WB_ARB: begin
               if (arb_gnt) begin
                  r_state    <= WB_ADDR;
                  bus_reqcyc <= 1'b1;
                  bus_req    <= BUS_DATA_WIDTH'({w_head_addr, 6'b0});
                  bus_reqtag <= BUS_TAG_WIDTH'(SYSBUS_WR_TAG);
               end
            end
            WB_ADDR: begin
               if (bus_reqack) begin
                  r_state <= WB_DATA;
                  r_beat  <= '0;
                  bus_req <= w_head_line[0 +: BUS_DATA_WIDTH];
               end
            end
            WB_DATA: begin
               if (r_beat == BEAT_W'(BEATS - 1)) begin
                  r_state    <= WB_DONE;
                  r_beat     <= '0;
                  arb_req    <= 1'b0;
                  bus_reqcyc <= 1'b0;
                  bus_req    <= '0;
                  bus_reqtag <= '0;
               end else begin
                  r_beat  <= w_next_beat;
                  bus_req <= w_head_line[w_next_beat * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
               end
            end
            WB_DONE: begin
               // Head pops this edge; continue if anything is left behind it.
               if (w_multi || w_append) begin
                  r_state <= WB_ARB;
                  arb_req <= 1'b1;
               end else begin
                  r_state <= WB_IDLE;
               end
            end
            default: r_state <= WB_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_writeback_buffer
// Description : Directed self-checking bench for dcache_writeback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_writeback_buffer;

   logic         clk;
   logic         reset;
   logic         wb_valid;
   logic         wb_ready;
   logic [63:0]  wb_addr;
   logic [511:0] wb_line;
   logic [63:0]  lk_addr;
   logic         lk_hit;
   logic [511:0] lk_line;
   logic         busy;
   logic         arb_req;
   logic         arb_gnt;
   logic         bus_reqcyc;
   logic [63:0]  bus_req;
   logic [12:0]  bus_reqtag;
   logic         bus_reqack;
   logic         bus_respack;

   int checks   = 0;
   int failures = 0;

   localparam logic [12:0] WR_TAG = 13'h1100;

   dcache_writeback_buffer dut (
      .clk         (clk),
      .reset       (reset),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_line     (wb_line),
      .lk_addr     (lk_addr),
      .lk_hit      (lk_hit),
      .lk_line     (lk_line),
      .busy        (busy),
      .arb_req     (arb_req),
      .arb_gnt     (arb_gnt),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respack (bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   function automatic logic [511:0] mk_line(input logic [63:0] base);
      logic [511:0] l;
      l = '0;
      for (int i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] addr, input logic [63:0] base);
      wb_valid = 1'b1;
      wb_addr  = addr;
      wb_line  = mk_line(base);
      tick();
      wb_valid = 1'b0;
   endtask

   // Eight data beats starting at the current cycle, then DONE.
   task automatic data_beats(input string tag, input logic [63:0] base);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_beat%0d", tag, i), {bus_reqcyc, bus_req}, {1'b1, base + 64'(i)});
         tick();
      end
      chk({tag, "_done_reqcyc"}, bus_reqcyc, 1'b0);
      chk({tag, "_done_arbreq"}, arb_req, 1'b0);
   endtask

   // Wait (bounded) for an address beat, check it, then its data.
   task automatic burst(input string tag, input logic [63:0] addr, input logic [63:0] base);
      int n;
      n = 0;
      while (bus_reqcyc !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_start"}, bus_reqcyc, 1'b1);
      chk({tag, "_addr"}, bus_req, addr);
      chk({tag, "_tag"}, bus_reqtag, WR_TAG);
      chk({tag, "_arbreq"}, arb_req, 1'b1);
      tick();
      data_beats(tag, base);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      logic seen_cyc;
      reset      = 1'b0;
      wb_valid   = 1'b0;
      wb_addr    = '0;
      wb_line    = '0;
      lk_addr    = 64'h6000;
      arb_gnt    = 1'b0;
      bus_reqack = 1'b0;
      tick();
      tick();

      // ---- reset state ----
      chk("rst_wb_ready", wb_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_arb_req", arb_req, 1'b0);
      chk("rst_reqcyc", bus_reqcyc, 1'b0);
      chk("rst_bus_req", bus_req, 64'h0);
      chk("rst_tag", bus_reqtag, 13'h0);
      chk("rst_lk_hit", lk_hit, 1'b0);
      chk("rst_respack", bus_respack, 1'b0);
      reset = 1'b1;
      tick();

      // ---- single eviction, immediate grant/ack ----
      arb_gnt    = 1'b1;
      bus_reqack = 1'b1;
      push(64'h1040, 64'hA0);
      chk("single_busy", busy, 1'b1);
      chk("single_arb_n0", arb_req, 1'b0);
      tick();
      chk("single_arb_n1", arb_req, 1'b1);
      tick();
      chk("single_addr_n2", bus_reqcyc, 1'b1);
      burst("single", 64'h1040, 64'hA0);
      tick();
      chk("single_end_busy", busy, 1'b0);
      chk("single_end_cyc", bus_reqcyc, 1'b0);

      // ---- backpressure and back-to-back bursts ----
      bus_reqack = 1'b0;
      push(64'h2000, 64'hB0);
      push(64'h3000, 64'hC0);
      tick();
      chk("bp_addr", {bus_reqcyc, bus_req, bus_reqtag}, {1'b1, 64'h2000, WR_TAG});
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_hold%0d", i), {bus_reqcyc, bus_req, bus_reqtag}, {1'b1, 64'h2000, WR_TAG});
      end
      bus_reqack = 1'b1;
      tick();
      data_beats("bp_first", 64'hB0);
      burst("bp_second", 64'h3000, 64'hC0);
      wait_idle("bp");

      // ---- full / coalesce / lookup ----
      arb_gnt = 1'b0;
      push(64'h4000, 64'hD0);
      push(64'h5000, 64'hE0);
      wb_addr = 64'h6000;
      #1;
      chk("full_ready_miss", wb_ready, 1'b0);
      wb_addr = 64'h4000;
      #1;
      chk("full_ready_head", wb_ready, 1'b0);
      wb_addr = 64'h5008;
      #1;
      chk("full_ready_match", wb_ready, 1'b1);
      push(64'h5008, 64'hF0);
      wb_addr = 64'h6000;
      #1;
      chk("coal_count_kept", wb_ready, 1'b0);
      lk_addr = 64'h4038;
      #1;
      chk("lk_4000", {lk_hit, lk_line}, {1'b1, mk_line(64'hD0)});
      lk_addr = 64'h5000;
      #1;
      chk("lk_5000_coal", {lk_hit, lk_line}, {1'b1, mk_line(64'hF0)});
      lk_addr = 64'h4038;
      arb_gnt = 1'b1;
      burst("coal_first", 64'h4000, 64'hD0);
      chk("lk_4000_in_done", lk_hit, 1'b1);
      tick();
      chk("lk_4000_popped", lk_hit, 1'b0);
      burst("coal_second", 64'h5000, 64'hF0);
      wait_idle("coal");
      lk_addr = 64'h6000;
      #1;
      chk("lk_miss", {lk_hit, lk_line}, {1'b0, 512'h0});

      // ---- append behind in-flight head ----
      lk_addr = 64'h7000;
      push(64'h7000, 64'h100);
      tick();
      tick();
      chk("app_addr", {bus_reqcyc, bus_req}, {1'b1, 64'h7000});
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("app_a_beat%0d", i), bus_req, 64'h100 + 64'(i));
         if (i < 3) tick();
      end
      chk("app_ready", wb_ready, 1'b1);
      push(64'h7000, 64'h200);
      chk("app_lk_young", {lk_hit, lk_line}, {1'b1, mk_line(64'h200)});
      for (int i = 4; i < 8; i++) begin
         chk($sformatf("app_a_beat%0d", i), bus_req, 64'h100 + 64'(i));
         tick();
      end
      chk("app_a_done", bus_reqcyc, 1'b0);
      burst("app_b", 64'h7000, 64'h200);
      tick();
      chk("app_lk_gone", lk_hit, 1'b0);
      wait_idle("app");

      // ---- asynchronous reset mid-burst ----
      lk_addr = 64'h8000;
      push(64'h8000, 64'h300);
      for (int i = 0; i < 7; i++) tick();
      chk("rstmid_beat4", {bus_reqcyc, bus_req}, {1'b1, 64'h304});
      #2;
      reset = 1'b0;
      #1;
      chk("rstmid_cyc", bus_reqcyc, 1'b0);
      chk("rstmid_arb", arb_req, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_lk", lk_hit, 1'b0);
      tick();
      reset = 1'b1;
      seen_cyc = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus_reqcyc === 1'b1 || arb_req === 1'b1) seen_cyc = 1'b1;
      end
      chk("rstmid_no_beats", seen_cyc, 1'b0);
      chk("rstmid_after_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
